// File: rtl/fetch_buffer.sv
// fetch_buffer: small circular instruction/PC queue between the instruction-memory
// response path and the IF/ID register. Absorbs fetches while decode is stalled
// and drops everything on a branch/jump flush.
module fetch_buffer #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 32
) (
   input  logic                       clk_i,
   input  logic                       reset_n,
   input  logic                       enq_valid_i,
   input  logic [WIDTH-1:0]           enq_instr_i,
   input  logic [WIDTH-1:0]           enq_pc_i,
   output logic                       enq_ready_o,
   input  logic                       deq_en_i,
   output logic                       deq_valid_o,
   output logic [WIDTH-1:0]           deq_instr_o,
   output logic [WIDTH-1:0]           deq_pc_o,
   input  logic                       flush_i,
   output logic [$clog2(DEPTH):0]     count_o,
   output logic                       almost_full_o
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam logic [WIDTH-1:0] NOP = WIDTH'(32'h0000_0013);

   logic [WIDTH-1:0] r_instr_mem [DEPTH];
   logic [WIDTH-1:0] r_pc_mem    [DEPTH];
   logic [AW-1:0]    r_rd_ptr;
   logic [AW-1:0]    r_wr_ptr;
   logic [CW-1:0]    r_count;

   logic             w_ready;
   logic             w_valid;
   logic             w_enq;
   logic             w_deq;
   logic [AW-1:0]    w_rd_ptr_nxt;
   logic [AW-1:0]    w_wr_ptr_nxt;
   logic [CW-1:0]    w_count_nxt;

   assign w_ready = (r_count < CW'(DEPTH));
   assign w_valid = (r_count != {CW{1'b0}});
   assign w_enq   = enq_valid_i && w_ready;
   assign w_deq   = deq_en_i && w_valid;

   // Next pointer/count state; flush overrides any same-cycle enqueue or dequeue.
   always_comb begin
      w_rd_ptr_nxt = r_rd_ptr;
      w_wr_ptr_nxt = r_wr_ptr;
      w_count_nxt  = r_count;
      if (flush_i) begin
         w_rd_ptr_nxt = {AW{1'b0}};
         w_wr_ptr_nxt = {AW{1'b0}};
         w_count_nxt  = {CW{1'b0}};
      end else begin
         if (w_enq) begin
            w_wr_ptr_nxt = r_wr_ptr + AW'(1);
         end else begin
            w_wr_ptr_nxt = r_wr_ptr;
         end
         if (w_deq) begin
            w_rd_ptr_nxt = r_rd_ptr + AW'(1);
         end else begin
            w_rd_ptr_nxt = r_rd_ptr;
         end
         case ({w_enq, w_deq})
            2'b10:   w_count_nxt = r_count + CW'(1);
            2'b01:   w_count_nxt = r_count - CW'(1);
            default: w_count_nxt = r_count;
         endcase
      end
   end

   // Pointer and occupancy registers; reset empties the buffer immediately.
   always_ff @(posedge clk_i or negedge reset_n) begin
      if (!reset_n) begin
         r_rd_ptr <= {AW{1'b0}};
         r_wr_ptr <= {AW{1'b0}};
         r_count  <= {CW{1'b0}};
      end else begin
         r_rd_ptr <= w_rd_ptr_nxt;
         r_wr_ptr <= w_wr_ptr_nxt;
         r_count  <= w_count_nxt;
      end
   end

   // Entry storage: instruction and PC are written as a pair; contents need no reset.
   always_ff @(posedge clk_i) begin
      if (w_enq && !flush_i) begin
         r_instr_mem[r_wr_ptr] <= enq_instr_i;
         r_pc_mem[r_wr_ptr]    <= enq_pc_i;
      end
   end

   // Head presentation from registered state only; empty shows a NOP at PC 0.
   always_comb begin
      deq_valid_o   = w_valid;
      enq_ready_o   = w_ready;
      count_o       = r_count;
      almost_full_o = (r_count >= CW'(DEPTH - 1));
      if (w_valid) begin
         deq_instr_o = r_instr_mem[r_rd_ptr];
         deq_pc_o    = r_pc_mem[r_rd_ptr];
      end else begin
         deq_instr_o = NOP;
         deq_pc_o    = {WIDTH{1'b0}};
      end
   end

endmodule

// File: doc/fetch_buffer.md
Name: fetch_buffer

Overview:
- Small instruction queue between the instruction-memory response path and the IF/ID pipeline register.
- Absorbs fetched instruction/PC pairs while the decode side is stalled, i.e. while the IF/ID register enable is low.
- Presents the oldest entry to the IF/ID register.
- Discards all contents on a branch/jump flush so the fetch stage can keep issuing requests without waiting on decode.

Parameters:
- DEPTH, 4, number of entries; power of two, at least 2.
- WIDTH, 32, instruction and PC width in bits.

Ports:
- clk_i  input  1  single clock; all state updates on the rising edge.
- reset_n  input  1  reset, asynchronous and active-low.
- enq_valid_i  input  1  a fetched instruction is offered this cycle.
- enq_instr_i  input  WIDTH  fetched instruction.
- enq_pc_i  input  WIDTH  PC of the fetched instruction.
- enq_ready_o  output  1  buffer can accept an entry this cycle.
- deq_en_i  input  1  IF/ID register enable; when high, the head entry is consumed this edge.
- deq_valid_o  output  1  head entry valid.
- deq_instr_o  output  WIDTH  head instruction; a NOP (32'h00000013) when deq_valid_o is 0.
- deq_pc_o  output  WIDTH  head PC; 0 when deq_valid_o is 0.
- flush_i  input  1  discard all entries (branch/jump redirect).
- count_o  output  $clog2(DEPTH)+1  current occupancy.
- almost_full_o  output  1  count_o >= DEPTH-1.

Behaviour:
- Storage is a circular array with read pointer, write pointer and occupancy count. Pointers wrap modulo DEPTH.
- Reset (reset_n low, asynchronous):
  - pointers = 0, count_o = 0, deq_valid_o = 0.
  - deq_instr_o = NOP, deq_pc_o = 0.
  - enq_ready_o = 1, almost_full_o = 0.
  - Storage contents need not be cleared.
  - A reset asserted mid-operation empties the buffer immediately, without waiting for a clock edge.
- Outputs are a function of registered state only; no combinational path from enq_* to deq_*.
  - An entry written at edge N is visible on deq_* after edge N, i.e. one-cycle minimum latency.
- enq_ready_o = (count_o < DEPTH).
  - Enqueue happens when enq_valid_i && enq_ready_o.
  - When full, offered data is not accepted and not stored; upstream holds it.
  - enq_ready_o does not depend on deq_en_i: no simultaneous enqueue+dequeue when full.
- deq_valid_o = (count_o != 0).
  - Dequeue happens when deq_en_i && deq_valid_o.
  - deq_en_i while empty is a no-op.
- Simultaneous enqueue and dequeue: both pointers advance; count unchanged.
- Dequeue only: count decrements. Enqueue only: count increments.
- flush_i has priority over everything:
  - On an edge with flush_i high, pointers and count return to 0.
  - A same-cycle enqueue is dropped.
  - A same-cycle dequeue has no further effect.
  - deq_valid_o is 0 in the cycle after the flush.
- Ordering is strict FIFO; instruction and PC are stored and popped as a pair.
- No overflow or underflow is reachable under these rules. The count never exceeds DEPTH and never goes below 0.

Test Plan:
- Reset and basic pass-through:
  - Stimulus: reset_n low for 2 cycles; release; enqueue {instr 32'h00500093, pc 0x0}; deq_en_i = 1.
  - Response: during reset, deq_valid_o = 0 and deq_instr_o = 32'h00000013. One edge after enqueue, deq_valid_o = 1, deq_instr_o = 32'h00500093, deq_pc_o = 0. After the next edge, count_o = 0.
- Fill under stall (DEPTH = 4):
  - Stimulus: deq_en_i = 0; enqueue PCs 0x0, 0x4, 0x8, 0xC; then offer 0x10.
  - Response: count_o = 3 sets almost_full_o = 1. Then count_o = 4, enq_ready_o = 0, 0x10 not accepted, deq_pc_o = 0x0.
- Drain order with wrap-around:
  - Stimulus: from full, deq_en_i = 1; release 0x10 and keep enqueuing 0x10, 0x14.
  - Response: deq_pc_o sequence is 0x0, 0x4, 0x8, 0xC, 0x10, 0x14 with no gaps or duplicates; write pointer wraps past index 3.
- Simultaneous enqueue/dequeue at count 2:
  - Stimulus: one edge with both enqueue and dequeue.
  - Response: count_o stays 2 and head advances to the next PC.
- Flush with concurrent traffic:
  - Stimulus: count 3; assert flush_i with enq_valid_i = 1 and deq_en_i = 1.
  - Response: next cycle count_o = 0, deq_valid_o = 0, deq_instr_o = NOP; the flushed-cycle enqueue is absent. A subsequent enqueue of pc 0x100 appears at the head.
- Asynchronous reset mid-operation:
  - Stimulus: count 2; pull reset_n low between clock edges.
  - Response: deq_valid_o = 0 and count_o = 0 before the next rising edge. After release, the buffer operates normally from empty.
